// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_sb_pkg                                              |
// | Brief  : Shared CPU constants for the register file / scoreboard     |
// |          (default data width, address width, hard-wired zero reg).   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package regfile_sb_pkg;

  // Architectural defaults, also used by the single-cycle datapath
  localparam int c_DATA_W   = 32;
  localparam int c_ADDR_W   = 5;
  localparam int c_ZERO_REG = 1;

  // Number of architectural registers addressable with a given width
  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage : regfile_sb_pkg
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_sb_if                                               |
// | Brief  : Bus bundle for the register file: two read ports with busy  |
// |          flags, one writeback port and one issue (reserve) port.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W
) ();

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] input_data;
  logic              issue;
  logic [ADDR_W-1:0] issue_rd;

  // Pipeline side: supplies addresses / writeback / issue, consumes reads
  modport master (
    output rs, rt, write, rd, input_data, issue, issue_rd,
    input  rs_data, rt_data, rs_busy, rt_busy
  );

  // Register file side
  modport slave (
    input  rs, rt, write, rd, input_data, issue, issue_rd,
    output rs_data, rt_data, rs_busy, rt_busy
  );

endinterface : regfile_sb_if
`default_nettype wire

// File: rtl/regfile_sb_rdport.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_rdport                                              |
// | Brief  : One combinational read port: selects a register and its     |
// |          busy bit, with write-through bypass and zero-reg handling.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile_rdport
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int ZERO_REG = c_ZERO_REG
) (
  input  wire logic                                i_rst_n,
  input  wire logic [ADDR_W-1:0]                   i_addr,
  input  wire logic [(2**ADDR_W)-1:0][DATA_W-1:0]  i_regs,
  input  wire logic [(2**ADDR_W)-1:0]              i_busy,
  input  wire logic                                i_wr_en,
  input  wire logic [ADDR_W-1:0]                   i_wr_addr,
  input  wire logic [DATA_W-1:0]                   i_wr_data,
  output logic      [DATA_W-1:0]                   o_data,
  output logic                                     o_busy
);

  logic w_zero_hit;
  logic w_bypass_hit;

  // i_wr_en is already qualified against the zero register by the parent
  assign w_zero_hit   = (ZERO_REG != 0) && (i_addr == '0);
  assign w_bypass_hit = i_wr_en && (i_wr_addr == i_addr);

  // Priority: reset blanks everything, then the zero register, then the
  // in-flight writeback (which also retires the pending producer), then
  // stored state.
  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (!i_rst_n || w_zero_hit) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (w_bypass_hit) begin
      o_data = i_wr_data;
      o_busy = 1'b0;
    end else begin
      o_data = i_regs[i_addr];
      o_busy = i_busy[i_addr];
    end
  end

endmodule : regfile_rdport
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_sb                                                  |
// | Brief  : 2-read / 1-write register file with a per-register busy     |
// |          scoreboard, write-through bypass and optional zero register.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int ZERO_REG = c_ZERO_REG
) (
  input wire logic     clk,
  input wire logic     rst,    // asynchronous, active-low
  regfile_sb_if.slave  bus
);

  localparam int c_NREGS = 2**ADDR_W;

  logic [c_NREGS-1:0][DATA_W-1:0] r_regs;
  logic [c_NREGS-1:0]             r_busy;

  logic              w_wr_en;
  logic              w_iss_en;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic              w_rs_busy;
  logic              w_rt_busy;

  // Writes and issues aimed at a hard-wired zero register are dropped here,
  // so neither storage nor bypass ever sees them.
  assign w_wr_en  = bus.write && !((ZERO_REG != 0) && (bus.rd == '0));
  assign w_iss_en = bus.issue && !((ZERO_REG != 0) && (bus.issue_rd == '0));

  // Storage and scoreboard update; an issue beats a writeback to the same
  // register because the newly issued producer has not produced yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < c_NREGS; i++) begin
        if (w_wr_en && (bus.rd == ADDR_W'(i))) begin
          r_regs[i] <= bus.input_data;
        end
        if (w_iss_en && (bus.issue_rd == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_en && (bus.rd == ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  regfile_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rdport_rs (
    .i_rst_n   (rst),
    .i_addr    (bus.rs),
    .i_regs    (r_regs),
    .i_busy    (r_busy),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (bus.rd),
    .i_wr_data (bus.input_data),
    .o_data    (w_rs_data),
    .o_busy    (w_rs_busy)
  );

  regfile_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rdport_rt (
    .i_rst_n   (rst),
    .i_addr    (bus.rt),
    .i_regs    (r_regs),
    .i_busy    (r_busy),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (bus.rd),
    .i_wr_data (bus.input_data),
    .o_data    (w_rt_data),
    .o_busy    (w_rt_busy)
  );

  assign bus.rs_data = w_rs_data;
  assign bus.rt_data = w_rt_data;
  assign bus.rs_busy = w_rs_busy;
  assign bus.rt_busy = w_rt_busy;

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_regfile_sb                                               |
// | Brief  : Self-checking bench for regfile_sb (ZERO_REG=1 main DUT,    |
// |          ZERO_REG=0 companion for the zero-register comparison).     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference state of the ZERO_REG=1 DUT
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic idle();
    bus.rs = '0;  bus.rt = '0;  bus.write = 1'b0;  bus.rd = '0;
    bus.input_data = '0;  bus.issue = 1'b0;  bus.issue_rd = '0;
    bus0.rs = '0; bus0.rt = '0; bus0.write = 1'b0; bus0.rd = '0;
    bus0.input_data = '0; bus0.issue = 1'b0; bus0.issue_rd = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Expected read value: register contents as seen by the pipeline this cycle
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (!rst || a == 0) return '0;
    if (bus.write && bus.rd == a) return bus.input_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!rst || a == 0) return 1'b0;
    if (bus.write && bus.rd == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply this cycle's writeback then issue to the model, advance one edge
  task automatic tick();
    if (rst) begin
      if (bus.write && bus.rd != 0) begin
        m_regs[bus.rd] = bus.input_data;
        m_busy[bus.rd] = 1'b0;
      end
      if (bus.issue && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    model_clear();
    bus.rs = 5'd3; bus.rt = 5'd17; bus.write = 1'b1; bus.rd = 5'd3;
    bus.input_data = 32'hCAFEF00D;
    #2;
    checks++;
    if (bus.rs_data !== 32'h0) begin
      errors++; $display("FAIL reset_bypass_suppressed: got %h expected 0", bus.rs_data);
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < NR; a++) begin
      bus.rs = AW'(a);
      bus.rt = AW'(NR - 1 - a);
      #2;
      checks++;
      if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0 || bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_read a=%0d: got rs=%h rt=%h bs=%b bt=%b expected all 0",
                 a, bus.rs_data, bus.rt_data, bus.rs_busy, bus.rt_busy);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.write = 1'b1; bus.rd = 5'd5; bus.input_data = 32'hDEADBEEF; bus.rs = 5'd5;
    #2;
    checks++;
    if (bus.rs_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", bus.rs_data);
    end
    tick();
    bus.write = 1'b0;
    #2;
    checks++;
    if (bus.rs_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_stored: got %h expected deadbeef", bus.rs_data);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue = 1'b1; bus.issue_rd = 5'd7;
    tick();
    idle();
    bus.rt = 5'd7;
    #2;
    checks++;
    if (bus.rt_busy !== 1'b1) begin
      errors++; $display("FAIL sb_busy_set: got %b expected 1", bus.rt_busy);
    end
    tick();
    bus.write = 1'b1; bus.rd = 5'd7; bus.input_data = 32'h12;
    #2;
    checks++;
    if (bus.rt_busy !== 1'b0 || bus.rt_data !== 32'h12) begin
      errors++; $display("FAIL sb_write_clear: got busy=%b data=%h expected 0/00000012", bus.rt_busy, bus.rt_data);
    end
    tick();
    bus.write = 1'b0;
    #2;
    checks++;
    if (bus.rt_busy !== 1'b0 || bus.rt_data !== 32'h12) begin
      errors++; $display("FAIL sb_after_write: got busy=%b data=%h expected 0/00000012", bus.rt_busy, bus.rt_data);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    idle();
    bus.issue = 1'b1; bus.issue_rd = 5'd9;
    bus.write = 1'b1; bus.rd = 5'd9; bus.input_data = 32'h55; bus.rs = 5'd9;
    tick();
    idle();
    bus.rs = 5'd9;
    #2;
    checks++;
    if (bus.rs_busy !== 1'b1 || bus.rs_data !== 32'h55) begin
      errors++; $display("FAIL issue_write_same: got busy=%b data=%h expected 1/00000055", bus.rs_busy, bus.rs_data);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    bus.write  = 1'b1; bus.rd  = '0; bus.input_data  = 32'hFFFFFFFF; bus.issue  = 1'b1; bus.issue_rd  = '0;
    bus0.write = 1'b1; bus0.rd = '0; bus0.input_data = 32'hFFFFFFFF; bus0.issue = 1'b1; bus0.issue_rd = '0;
    #2;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rs_busy !== 1'b0) begin
      errors++; $display("FAIL zero_no_bypass: got data=%h busy=%b expected 0/0", bus.rs_data, bus.rs_busy);
    end
    checks++;
    if (bus0.rs_data !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL nozero_bypass: got %h expected ffffffff", bus0.rs_data);
    end
    tick();
    idle();
    #2;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rs_busy !== 1'b0) begin
      errors++; $display("FAIL zero_reg_read: got data=%h busy=%b expected 0/0", bus.rs_data, bus.rs_busy);
    end
    checks++;
    if (bus0.rs_data !== 32'hFFFFFFFF || bus0.rs_busy !== 1'b1) begin
      errors++; $display("FAIL nozero_reg_read: got data=%h busy=%b expected ffffffff/1", bus0.rs_data, bus0.rs_busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    for (int k = 1; k <= 3; k++) begin
      bus.write = 1'b1; bus.rd = 5'd4; bus.input_data = 32'h100 + 32'(k); bus.rt = 5'd4;
      #2;
      checks++;
      if (bus.rt_data !== 32'h100 + 32'(k)) begin
        errors++; $display("FAIL b2b_write k=%0d: got %h expected %h", k, bus.rt_data, 32'h100 + 32'(k));
      end
      tick();
    end
    bus.write = 1'b0;
    #2;
    checks++;
    if (bus.rt_data !== 32'h103) begin
      errors++; $display("FAIL b2b_final: got %h expected 00000103", bus.rt_data);
    end
    tick();
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 400; n++) begin
      bus.write      = 1'($urandom_range(0, 1));
      bus.rd         = AW'($urandom);
      bus.input_data = $urandom;
      bus.issue      = ($urandom_range(0, 3) == 0);
      bus.issue_rd   = AW'($urandom);
      bus.rs         = ($urandom_range(0, 3) == 0) ? bus.rd : AW'($urandom);
      bus.rt         = ($urandom_range(0, 7) == 0) ? bus.rs : AW'($urandom);
      #2;
      checks++;
      if (bus.rs_data !== exp_data(bus.rs) || bus.rs_busy !== exp_busy(bus.rs)) begin
        errors++;
        $display("FAIL rand_rs n=%0d rs=%0d: got %h/%b expected %h/%b",
                 n, bus.rs, bus.rs_data, bus.rs_busy, exp_data(bus.rs), exp_busy(bus.rs));
      end
      checks++;
      if (bus.rt_data !== exp_data(bus.rt) || bus.rt_busy !== exp_busy(bus.rt)) begin
        errors++;
        $display("FAIL rand_rt n=%0d rt=%0d: got %h/%b expected %h/%b",
                 n, bus.rt, bus.rt_data, bus.rt_busy, exp_data(bus.rt), exp_busy(bus.rt));
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle();
    for (int k = 1; k <= 3; k++) begin
      bus.write = 1'b1; bus.rd = AW'(k); bus.input_data = 32'hA0 + 32'(k);
      tick();
    end
    idle();
    bus.rs = 5'd1; bus.rt = 5'd2;
    #2;
    checks++;
    if (bus.rs_data !== 32'hA1 || bus.rt_data !== 32'hA2) begin
      errors++; $display("FAIL preload: got %h/%h expected 000000a1/000000a2", bus.rs_data, bus.rt_data);
    end
    #1;
    rst = 1'b0;
    model_clear();
    bus.write = 1'b1; bus.rd = 5'd2; bus.input_data = 32'h77; bus.issue = 1'b1; bus.issue_rd = 5'd2;
    #1;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0 || bus.rt_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset_now: got %h/%h busy=%b expected 0/0/0", bus.rs_data, bus.rt_data, bus.rt_busy);
    end
    tick();
    #1;
    checks++;
    if (bus.rt_data !== 32'h0 || bus.rt_busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got %h busy=%b expected 0/0", bus.rt_data, bus.rt_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    tick();
    for (int k = 1; k <= 3; k++) begin
      bus.rs = AW'(k); bus.rt = AW'(k);
      #2;
      checks++;
      if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0 || bus.rs_busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_read r%0d: got %h/%h busy=%b expected 0", k, bus.rs_data, bus.rt_data, bus.rs_busy);
      end
      tick();
    end
    bus.write = 1'b1; bus.rd = 5'd2; bus.input_data = 32'h99;
    tick();
    idle();
    bus.rs = 5'd2;
    #2;
    checks++;
    if (bus.rs_data !== 32'h99) begin
      errors++; $display("FAIL rewrite_after_reset: got %h expected 00000099", bus.rs_data);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bypass();
    test_scoreboard();
    test_same_cycle();
    test_zero_reg();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_sb
`default_nettype wire
